dmem_resp: RTL and testbench

DMEM_RESP -- requirements
Module: dmem_resp

---
 rtl/dmem_pkg.sv | 30 +++
 rtl/dmem_array.sv | 29 ++
 rtl/dmem_resp.sv | 144 ++++++++++++++
 tb/tb_dmem_resp.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the dmem_resp data-memory responder:
// FSM state encoding, latency bound, byte-mask patterns and the
// misalignment rule.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam int DMEM_MAX_LATENCY = 15;

  localparam logic [3:0] MASK_WORD    = 4'b1111;
  localparam logic [3:0] MASK_HALF_LO = 4'b0011;
  localparam logic [3:0] MASK_HALF_HI = 4'b1100;

  // A read or a full-word write must be word aligned; a half-word lane
  // pattern must be half-word aligned.
  function automatic logic dmem_misaligned(input logic [1:0] addr_lo,
                                           input logic [3:0] mask,
                                           input logic       is_write);
    logic is_word;
    logic is_half;
    is_word = !is_write || (mask == MASK_WORD);
    is_half = (mask == MASK_HALF_LO) || (mask == MASK_HALF_HI);
    return (is_word && (addr_lo != 2'b00)) || (is_half && addr_lo[0]);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage for dmem_resp: one synchronous write port with per-byte
// lane enables and one combinational read port. Contents are never reset.
module dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Lane-masked write; a zero lane mask leaves the word untouched.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/dmem_resp.sv
// Fixed-latency data-memory responder. One request at a time: accepted in
// IDLE, held in BUSY for the latency count, answered with a one-cycle
// pulse in RESP. Writes commit in the RESP cycle only.
// Optional build macro DMEM_BOUNDS_CHECK_EN: addresses at or beyond
// 4*DEPTH_WORDS raise o_dmem_err and suppress the write; without it the
// upper address bits are ignored and accesses wrap.
module dmem_resp
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_dmem_ren,
  input  logic        i_dmem_wen,
  input  logic [31:0] i_dmem_addr,
  input  logic [31:0] i_dmem_wdata,
  input  logic [3:0]  i_dmem_mask,
  output logic        o_dmem_ready,
  output logic        o_dmem_valid,
  output logic [31:0] o_dmem_rdata,
  output logic        o_dmem_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  // Handshake: a request is taken on a rising edge where ren|wen and ready
  // are both high; ready is high exactly in IDLE, so anything presented in
  // BUSY or RESP is dropped, never queued. valid is a single-cycle pulse
  // and qualifies rdata and err.
  dmem_state_t state;
  logic [3:0]  cnt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  mask_q;
  logic        wr_q;

  logic        accept;
  logic [31:0] src_addr;
  logic [3:0]  src_mask;
  logic        src_wr;
  logic        src_oob;
  logic        src_err;
  logic [31:0] arr_rdata;
  logic [31:0] resp_rdata;
  logic        arr_we;

  assign accept = (i_dmem_ren | i_dmem_wen) & o_dmem_ready;

  // The response is computed from live inputs when jumping straight from
  // IDLE to RESP (LATENCY=1), otherwise from the latched request.
  assign src_addr = (state == IDLE) ? i_dmem_addr : addr_q;
  assign src_mask = (state == IDLE) ? i_dmem_mask : mask_q;
  assign src_wr   = (state == IDLE) ? i_dmem_wen  : wr_q;

`ifdef DMEM_BOUNDS_CHECK_EN
  assign src_oob = |src_addr[31:AW+2];
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^src_addr[31:AW+2];
  assign src_oob = 1'b0;
`endif

  assign src_err    = dmem_misaligned(src_addr[1:0], src_mask, src_wr) | src_oob;
  assign resp_rdata = (!src_wr && !src_err) ? arr_rdata : 32'd0;

  // Erroring writes commit nothing.
  assign arr_we = (state == RESP) && wr_q && !o_dmem_err;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .i_clk  (i_clk),
    .i_we   (arr_we),
    .i_be   (mask_q),
    .i_waddr(addr_q[AW+1:2]),
    .i_wdata(wdata_q),
    .i_raddr(src_addr[AW+1:2]),
    .o_rdata(arr_rdata)
  );

  // Control FSM with registered handshake and response outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      o_dmem_ready <= 1'b1;
      o_dmem_valid <= 1'b0;
      o_dmem_err   <= 1'b0;
      o_dmem_rdata <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q       <= i_dmem_addr;
            wdata_q      <= i_dmem_wdata;
            mask_q       <= i_dmem_mask;
            wr_q         <= i_dmem_wen;
            o_dmem_ready <= 1'b0;
            if (LATENCY == 1) begin
              state        <= RESP;
              o_dmem_valid <= 1'b1;
              o_dmem_err   <= src_err;
              o_dmem_rdata <= resp_rdata;
            end else begin
              state <= BUSY;
              cnt   <= CNT_INIT;
            end
          end
        end
        BUSY: begin
          if (cnt == 4'd1) begin
            state        <= RESP;
            cnt          <= 4'd0;
            o_dmem_valid <= 1'b1;
            o_dmem_err   <= src_err;
            o_dmem_rdata <= resp_rdata;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state        <= IDLE;
          o_dmem_ready <= 1'b1;
          o_dmem_valid <= 1'b0;
          o_dmem_err   <= 1'b0;
          o_dmem_rdata <= 32'd0;
        end
        default: begin
          state        <= IDLE;
          cnt          <= 4'd0;
          o_dmem_ready <= 1'b1;
          o_dmem_valid <= 1'b0;
          o_dmem_err   <= 1'b0;
          o_dmem_rdata <= 32'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp with LATENCY=2, DEPTH_WORDS=1024.
module tb_dmem_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        ren;
  logic        wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  mask;
  logic        ready;
  logic        valid;
  logic [31:0] rdata;
  logic        err;

  int checks   = 0;
  int failures = 0;

  dmem_resp #(
    .DEPTH_WORDS(1024),
    .LATENCY    (2)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_dmem_ren  (ren),
    .i_dmem_wen  (wen),
    .i_dmem_addr (addr),
    .i_dmem_wdata(wdata),
    .i_dmem_mask (mask),
    .o_dmem_ready(ready),
    .o_dmem_valid(valid),
    .o_dmem_rdata(rdata),
    .o_dmem_err  (err)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    ren   = 1'b0;
    wen   = 1'b0;
    addr  = 32'd0;
    wdata = 32'd0;
    mask  = 4'd0;
  endtask

  // One full transaction; checks latency, the response flags and that
  // ready comes back the cycle after the response.
  task automatic txn(input string tag, input logic r, input logic w,
                     input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                     input logic [31:0] exp_rdata, input logic exp_err);
    int lat;
    lat = 0;
    check({tag, "_ready_before"}, {31'd0, ready}, 32'd1);
    ren = r; wen = w; addr = a; wdata = d; mask = m;
    @(posedge clk); #1;
    idle_inputs();
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (valid) begin
        lat = i;
        break;
      end
    end
    check({tag, "_latency"}, lat, 32'd2);
    check({tag, "_rdata"}, rdata, exp_rdata);
    check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    @(negedge clk);
    check({tag, "_ready_after"}, {31'd0, ready}, 32'd1);
    check({tag, "_valid_after"}, {31'd0, valid}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int nvalid;
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state
    @(negedge clk);
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_err",   {31'd0, err},   32'd0);
    check("rst_rdata", rdata,          32'd0);
    @(posedge clk); #1;

    // basic word write and read-back
    txn("wr10",   1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'd0, 1'b0);
    txn("rd10",   1'b1, 1'b0, 32'h10, 32'd0,        4'hF, 32'hDEADBEEF, 1'b0);
    // byte lane 0 write
    txn("wrb10",  1'b0, 1'b1, 32'h10, 32'h000000AA, 4'b0001, 32'd0, 1'b0);
    txn("rdb10",  1'b1, 1'b0, 32'h10, 32'd0,        4'hF, 32'hDEADBEAA, 1'b0);
    // misaligned accesses
    txn("rd12",   1'b1, 1'b0, 32'h12, 32'd0,        4'hF, 32'd0, 1'b1);
    txn("wr13",   1'b0, 1'b1, 32'h13, 32'h55,       4'hF, 32'd0, 1'b1);
    txn("wrh11",  1'b0, 1'b1, 32'h11, 32'h0000FFFF, 4'b0011, 32'd0, 1'b1);
    txn("rdun10", 1'b1, 1'b0, 32'h10, 32'd0,        4'hF, 32'hDEADBEAA, 1'b0);
    // aligned upper half-word write, then no-op write with empty mask
    txn("wrh12",  1'b0, 1'b1, 32'h12, 32'h12340000, 4'b1100, 32'd0, 1'b0);
    txn("wrm0",   1'b0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 32'd0, 1'b0);
    txn("rdh10",  1'b1, 1'b0, 32'h10, 32'd0,        4'hF, 32'h1234BEAA, 1'b0);
    // ren and wen together act as a write
    txn("rw14",   1'b1, 1'b1, 32'h14, 32'h11223344, 4'hF, 32'd0, 1'b0);
    txn("rd14",   1'b1, 1'b0, 32'h14, 32'd0,        4'hF, 32'h11223344, 1'b0);

    // request pulses while busy are ignored
    nvalid = 0;
    ren = 1'b1; addr = 32'h14; mask = 4'hF;
    @(posedge clk); #1;
    ren = 1'b0; wen = 1'b1; addr = 32'h14; wdata = 32'hFFFFFFFF; mask = 4'hF;
    @(negedge clk);
    if (valid) nvalid++;
    @(posedge clk); #1;
    @(negedge clk);
    if (valid) nvalid++;
    check("busy_rdata", rdata, 32'h11223344);
    @(posedge clk); #1;
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (valid) nvalid++;
    end
    check("busy_nvalid", nvalid, 32'd1);
    @(posedge clk); #1;
    txn("rdbusy14", 1'b1, 1'b0, 32'h14, 32'd0, 4'hF, 32'h11223344, 1'b0);

    // reset in BUSY abandons the write
    txn("wr20", 1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 32'd0, 1'b0);
    wen = 1'b1; addr = 32'h20; wdata = 32'h0BADBEEF; mask = 4'hF;
    @(posedge clk); #1;
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_ready", {31'd0, ready}, 32'd1);
    check("rstmid_valid", {31'd0, valid}, 32'd0);
    nvalid = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (valid) nvalid++;
    end
    check("rstmid_nvalid", nvalid, 32'd0);
    @(posedge clk); #1;
    txn("rd20", 1'b1, 1'b0, 32'h20, 32'd0, 4'hF, 32'hCAFEF00D, 1'b0);

    // out-of-range address: bounds error or wrap to word 0
    txn("wr00", 1'b0, 1'b1, 32'h0, 32'h0A0B0C0D, 4'hF, 32'd0, 1'b0);
`ifdef DMEM_BOUNDS_CHECK_EN
    txn("rd1000", 1'b1, 1'b0, 32'h1000, 32'd0, 4'hF, 32'd0, 1'b1);
`else
    txn("rd1000", 1'b1, 1'b0, 32'h1000, 32'd0, 4'hF, 32'h0A0B0C0D, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
